// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU operation encodings and default widths.
package ex_pkg;

    localparam int XLEN_DEF = 32;
    localparam int REGW_DEF = 5;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_MUL = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/ex_alu.sv
// Combinational ALU with zero flag. Define EX_MUL_EN to enable the low-half multiply
// on ALU_MUL; otherwise that op yields 0.
module ex_alu
    import ex_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      ctrl,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    localparam int SHW = $clog2(XLEN);

    logic signed [XLEN-1:0] a_s;
    logic signed [XLEN-1:0] b_s;

    assign a_s = a;
    assign b_s = b;

    always_comb begin
        result = '0;
        case (ctrl)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = a + b;
`ifdef EX_MUL_EN
            // Low half of the product is the same for signed and unsigned operands.
            ALU_MUL: result = a * b;
`else
            ALU_MUL: result = '0;
`endif
            ALU_XOR: result = a ^ b;
            ALU_SRL: result = a >> b[SHW-1:0];
            ALU_SUB: result = a - b;
            ALU_SLT: result = {{(XLEN-1){1'b0}}, (a_s < b_s)};
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/execute_stage.sv
// Execute stage: ALU, branch/jump target adder and the E/M pipeline register.
// EX_MUL_EN (see ex_alu) selects whether ALU_MUL performs a multiply.
module execute_stage
    import ex_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int REGW = REGW_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic [XLEN-1:0] pc_e,
    input  logic [XLEN-1:0] src_a_e,
    input  logic [XLEN-1:0] src_b_e,
    input  logic [XLEN-1:0] imm_e,
    input  logic [2:0]      alu_ctrl_e,
    input  logic [XLEN-1:0] write_data_e,
    input  logic [REGW-1:0] write_reg_e,
    output logic [XLEN-1:0] alu_result_e,
    output logic [XLEN-1:0] alu_out_m,
    output logic            zero_m,
    output logic [XLEN-1:0] target_m,
    output logic [XLEN-1:0] write_data_m,
    output logic [REGW-1:0] write_reg_m,
    output logic [XLEN-1:0] pc_m
);

    logic            zero_e;
    logic [XLEN-1:0] target_e;

    ex_alu #(.XLEN(XLEN)) u_alu (
        .a      (src_a_e),
        .b      (src_b_e),
        .ctrl   (alu_ctrl_e),
        .result (alu_result_e),
        .zero   (zero_e)
    );

    // Immediate is already byte-scaled upstream; the sum simply wraps.
    assign target_e = pc_e + imm_e;

    // E -> M boundary; en low (dcache miss) freezes the whole register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_out_m    <= '0;
            zero_m       <= 1'b0;
            target_m     <= '0;
            write_data_m <= '0;
            write_reg_m  <= '0;
            pc_m         <= '0;
        end else if (en) begin
            alu_out_m    <= alu_result_e;
            zero_m       <= zero_e;
            target_m     <= target_e;
            write_data_m <= write_data_e;
            write_reg_m  <= write_reg_e;
            pc_m         <= pc_e;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: stimulus pushes expected E/M contents, a monitor
// pops and compares after every clock edge that captures (and checks hold otherwise).
module tb_execute_stage;
    import ex_pkg::*;

    typedef struct {
        logic [31:0] alu;
        logic        zero;
        logic [31:0] tgt;
        logic [31:0] wd;
        logic [4:0]  wr;
        logic [31:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic [31:0] pc_e = '0;
    logic [31:0] src_a_e = '0;
    logic [31:0] src_b_e = '0;
    logic [31:0] imm_e = '0;
    logic [2:0]  alu_ctrl_e = '0;
    logic [31:0] write_data_e = '0;
    logic [4:0]  write_reg_e = '0;
    logic [31:0] alu_result_e;
    logic [31:0] alu_out_m;
    logic        zero_m;
    logic [31:0] target_m;
    logic [31:0] write_data_m;
    logic [4:0]  write_reg_m;
    logic [31:0] pc_m;

    int   errors = 0;
    int   checks = 0;
    bit   armed = 1'b0;
    exp_t sb[$];
    exp_t last;

    execute_stage #(.XLEN(32), .REGW(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .pc_e         (pc_e),
        .src_a_e      (src_a_e),
        .src_b_e      (src_b_e),
        .imm_e        (imm_e),
        .alu_ctrl_e   (alu_ctrl_e),
        .write_data_e (write_data_e),
        .write_reg_e  (write_reg_e),
        .alu_result_e (alu_result_e),
        .alu_out_m    (alu_out_m),
        .zero_m       (zero_m),
        .target_m     (target_m),
        .write_data_m (write_data_m),
        .write_reg_m  (write_reg_m),
        .pc_m         (pc_m)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_m(input string tag, input exp_t e);
        check({tag, ".alu_out_m"},    alu_out_m,             e.alu);
        check({tag, ".zero_m"},       {31'd0, zero_m},       {31'd0, e.zero});
        check({tag, ".target_m"},     target_m,              e.tgt);
        check({tag, ".write_data_m"}, write_data_m,          e.wd);
        check({tag, ".write_reg_m"},  {27'd0, write_reg_m},  {27'd0, e.wr});
        check({tag, ".pc_m"},         pc_m,                  e.pc);
    endtask

    // Drive one E-stage instruction with en=1 and queue its expected M-stage contents.
    task automatic issue(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, input logic [31:0] pc, input logic [31:0] imm,
                         input logic [31:0] wd, input logic [4:0] wr,
                         input logic [31:0] exp_alu, input logic [31:0] exp_tgt);
        exp_t e;
        @(negedge clk);
        src_a_e = a; src_b_e = b; alu_ctrl_e = op; pc_e = pc; imm_e = imm;
        write_data_e = wd; write_reg_e = wr; en = 1'b1;
        #1;
        check({name, ".alu_result_e"}, alu_result_e, exp_alu);
        e.alu = exp_alu; e.zero = (exp_alu == 32'd0); e.tgt = exp_tgt;
        e.wd = wd; e.wr = wr; e.pc = pc;
        sb.push_back(e);
    endtask

    task automatic stall(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                         input logic [31:0] pc, input logic [4:0] wr, input logic [31:0] exp_alu);
        @(negedge clk);
        src_a_e = a; src_b_e = b; alu_ctrl_e = op; pc_e = pc; write_reg_e = wr; en = 1'b0;
        #1;
        check("stall.alu_result_e", alu_result_e, exp_alu);
    endtask

    // Monitor: evaluates what the register should show after each rising edge.
    always @(posedge clk) begin
        logic s_en;
        logic s_rst;
        s_en  = en;
        s_rst = reset;
        #1;
        if (armed) begin
            if (!s_rst) begin
                last = '{32'd0, 1'b0, 32'd0, 32'd0, 5'd0, 32'd0};
                check_m("rst", last);
            end else if (s_en) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL capture: got capture with empty queue, expected none");
                end else begin
                    last = sb.pop_front();
                    check_m("cap", last);
                end
            end else begin
                check_m("hold", last);
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no finish, expected finish before 20000");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] mul_exp;
`ifdef EX_MUL_EN
        mul_exp = 32'd42;
`else
        mul_exp = 32'd0;
`endif
        last = '{32'd0, 1'b0, 32'd0, 32'd0, 5'd0, 32'd0};

        // Asynchronous clear before any clock edge, with busy inputs.
        src_a_e = 32'hDEAD_BEEF; src_b_e = 32'h1; alu_ctrl_e = ALU_ADD;
        pc_e = 32'h40; imm_e = 32'h8; write_data_e = 32'h55; write_reg_e = 5'd9; en = 1'b1;
        #2 reset = 1'b0;
        #1;
        check_m("async_rst", last);
        armed = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        en = 1'b0;

        issue("add",   32'd7, 32'd5, ALU_ADD, 32'h100, 32'h4, 32'hA1, 5'd1, 32'd12, 32'h104);
        issue("sub0",  32'h1234, 32'h1234, ALU_SUB, 32'h104, 32'h0, 32'hA2, 5'd2, 32'd0, 32'h104);
        issue("slt1",  32'hFFFF_FFFF, 32'd1, ALU_SLT, 32'h108, 32'h10, 32'hA3, 5'd3, 32'd1, 32'h118);
        issue("slt0",  32'd1, 32'hFFFF_FFFF, ALU_SLT, 32'h10C, 32'h0, 32'hA4, 5'd4, 32'd0, 32'h10C);
        issue("and",   32'hF0F0_F0F0, 32'h0FF0_0FF0, ALU_AND, 32'h110, 32'h0, 32'hA5, 5'd5,
              32'h00F0_00F0, 32'h110);
        issue("or",    32'hF0F0_F0F0, 32'h0FF0_0FF0, ALU_OR, 32'h114, 32'h0, 32'hA6, 5'd6,
              32'hFFF0_FFF0, 32'h114);
        issue("xor",   32'hF0F0_F0F0, 32'h0FF0_0FF0, ALU_XOR, 32'h118, 32'h0, 32'hA7, 5'd7,
              32'hFF00_FF00, 32'h118);
        issue("srl",   32'h8000_0000, 32'h24, ALU_SRL, 32'h11C, 32'h0, 32'hA8, 5'd8,
              32'h0800_0000, 32'h11C);
        issue("tgt_n", 32'd1, 32'd1, ALU_ADD, 32'h100, 32'hFFFF_FFF8, 32'hA9, 5'd9, 32'd2, 32'hF8);
        issue("tgt_w", 32'd1, 32'd1, ALU_ADD, 32'hFFFF_FFFC, 32'h8, 32'hAA, 5'd10, 32'd2, 32'h4);

        // Stall: capture 3+4, then three frozen edges while inputs show 9+9.
        issue("pre_stall", 32'd3, 32'd4, ALU_ADD, 32'h200, 32'h0, 32'hB0, 5'd11, 32'd7, 32'h200);
        repeat (3) stall(32'd9, 32'd9, ALU_ADD, 32'h300, 5'd22, 32'd18);
        issue("post_stall", 32'd9, 32'd9, ALU_ADD, 32'h300, 32'h0, 32'hB0, 5'd22, 32'd18, 32'h300);

        issue("mul",   32'd6, 32'd7, ALU_MUL, 32'h400, 32'h0, 32'hC0, 5'd12, mul_exp, 32'h400);

        // Mid-cycle asynchronous reset clears without waiting for a clock edge.
        @(negedge clk);
        en = 1'b0;
        #2 reset = 1'b0;
        #1;
        check_m("mid_rst", '{32'd0, 1'b0, 32'd0, 32'd0, 5'd0, 32'd0});
        @(negedge clk);
        reset = 1'b1;

        issue("after_rst", 32'd20, 32'd5, ALU_SUB, 32'h500, 32'h20, 32'hD0, 5'd13, 32'd15, 32'h520);

        @(negedge clk);
        en = 1'b0;
        repeat (2) @(negedge clk);
        check("queue_empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
Execute (E) stage of the 5-stage pipelined 32-bit processor, with the E/M pipeline register. Contents:
- Combinational ALU producing a result and a zero flag.
- Branch/jump target adder (PC + immediate).
- E->M register capturing ALU result, zero flag, target, store data, destination register and PC.
Sits between the D/E register (areg) and the memory/writeback register (rdreg). The fetch mux selects the target when BranchM & ZeroM.

Parameters:
XLEN, 32, datapath width (data, PC, immediate).
REGW, 5, destination register index width.

Ports:
clk  in  1  rising-edge clock.
reset  in  1  asynchronous, active-low reset (0 = reset asserted).
en  in  1  pipeline advance enable (driven by dcache hit); 0 = register holds.
pc_e  in  XLEN  PC of instruction in E.
src_a_e  in  XLEN  ALU operand A.
src_b_e  in  XLEN  ALU operand B (already muxed rd2/imm by ALUSrcE).
imm_e  in  XLEN  sign-extended immediate.
alu_ctrl_e  in  3  ALU operation.
write_data_e  in  XLEN  store data.
write_reg_e  in  REGW  destination register.
alu_result_e  out  XLEN  combinational ALU result (debug/forwarding).
alu_out_m  out  XLEN  registered ALU result.
zero_m  out  1  registered zero flag.
target_m  out  XLEN  registered branch/jump target.
write_data_m  out  XLEN  registered store data.
write_reg_m  out  REGW  registered destination.
pc_m  out  XLEN  registered PC.

Behaviour:
- ALU, combinational. Shift amount is src_b[4:0]; all arithmetic is modulo 2^32.
  - 000 AND.
  - 001 OR.
  - 010 ADD.
  - 011 MUL, low 32 bits (see Optional Feature).
  - 100 XOR.
  - 101 SRL (logical right shift of A by shift amount).
  - 110 SUB (A - B).
  - 111 SLT, signed: result is 1 if $signed(A) < $signed(B), else 0.
- zero = (result == 0), computed on the full 32-bit result.
- Target adder: target = pc_e + imm_e. No shift and no overflow detection; wraps modulo 2^32.
- E/M register:
  - Asynchronous clear: while reset == 0, all outputs *_m are 0, independent of clk.
  - On rising clk with reset == 1 and en == 1, captures alu result, zero, target, write_data_e, write_reg_e and pc_e.
  - With en == 0, all *_m hold their values.
  - Latency: 1 cycle from E inputs to *_m.
- Reset release mid-cycle: the first capture occurs at the first rising edge with reset high.
- No internal state other than the E/M register.

Optional Feature:
- Macro EX_MUL_EN.
  - Defined: op 011 gives the low 32 bits of A*B (unsigned/signed identical for low half); zero flag follows the result.
  - Undefined: op 011 gives 0 and zero = 1.
- All other ops are unaffected either way.

Decomposition:
- Package ex_pkg holds:
  - ALU op localparams: ALU_AND, ALU_OR, ALU_ADD, ALU_MUL, ALU_XOR, ALU_SRL, ALU_SUB, ALU_SLT.
  - XLEN/REGW defaults.
- One sub-module, ex_alu: the combinational ALU with zero flag.
- Target adder and E/M register stay inline in execute_stage.

Test Plan:
- Reset: drive reset=0 with non-zero inputs -> all *_m = 0 asynchronously. Release reset, A=7, B=5, op 010, en=1, one edge -> alu_out_m=12, zero_m=0.
- SUB/zero: A=B=0x1234, op 110 -> alu_result_e=0, after edge zero_m=1. SLT: A=0xFFFFFFFF, B=1, op 111 -> 1; A=1, B=0xFFFFFFFF -> 0.
- Logic/shift:
  - A=0xF0F0F0F0, B=0x0FF00FF0: AND=0x00F000F0, OR=0xFFF0FFF0, XOR=0xFF00FF00.
  - A=0x80000000, B=0x24 (shift amount 4), SRL -> 0x08000000.
- Target: pc_e=0x00000100, imm_e=0xFFFFFFF8 -> target_m=0x000000F8. pc_e=0xFFFFFFFC, imm_e=8 -> 0x00000004 (wrap).
- Stall: capture A=3, B=4 ADD (7). Drop en, change inputs to 9+9 -> after 3 edges alu_out_m stays 7 and write_reg_m/pc_m unchanged. Raise en -> 18 next edge.
- MUL: A=6, B=7, op 011 -> 42 with EX_MUL_EN; 0 and zero_m=1 without.
